// File: rtl/gol_pkg.sv
// Shared Game-of-Life types: board width, board vector and monitor FSM states.
package gol_pkg;

  localparam int BOARD_W = 16;

  typedef logic [BOARD_W-1:0] board_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_SHIFT   = 2'd2,
    S_HALT    = 2'd3
  } mon_state_e;

  function automatic logic board_is_dead(input board_t b, input logic lose);
    return (b == '0) || lose;
  endfunction

endpackage

// File: rtl/gol_gen_monitor_if.sv
// Board capture and serial output handshakes of the generation monitor.
interface gol_gen_monitor_if;
  import gol_pkg::*;

  logic   board_valid;
  board_t board_in;
  logic   lose_in;
  logic   ser_ready;
  logic   ser_valid;
  logic   ser_data;
  logic   ser_last;

  modport master (
    output board_valid, board_in, lose_in, ser_ready,
    input  ser_valid, ser_data, ser_last
  );

  modport slave (
    input  board_valid, board_in, lose_in, ser_ready,
    output ser_valid, ser_data, ser_last
  );

endinterface

// File: rtl/gol_board_serializer.sv
// Parallel-in/serial-out of one board, cell 0 first, with valid/ready and last/done.
module gol_board_serializer
  import gol_pkg::*;
(
  input  logic   clka,
  input  logic   restart_n,
  input  logic   load_i,
  input  board_t data_i,
  input  logic   ready_i,
  output logic   valid_o,
  output logic   data_o,
  output logic   last_o,
  output logic   done_o
);

  localparam int IDX_W = $clog2(BOARD_W);

  board_t           data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             at_last;

  assign at_last = (idx_q == IDX_W'(BOARD_W - 1));

  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      if (at_last) begin
        idx_d   = '0;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Gated by valid so the serial pins stay quiet between frames.
  assign valid_o = valid_q;
  assign data_o  = valid_q & data_q[idx_q];
  assign last_o  = valid_q & at_last;
  assign done_o  = valid_q & ready_i & at_last;

endmodule

// File: rtl/gol_gen_monitor.sv
// Generation monitor: counts generations, flags end-of-game, streams each board out.
// Optional generation cap is compiled in with GOL_MON_GEN_LIMIT_EN.
//
//   state     | meaning
//   S_IDLE    | waiting for board_valid, captures board into history
//   S_COMPARE | one cycle: update sticky dead/still/osc2/limit flags, load serializer
//   S_SHIFT   | streaming the 16 cells; leaves on last accepted bit
//   S_HALT    | game over, frozen until restart_n
module gol_gen_monitor
  import gol_pkg::*;
#(
  parameter int GEN_W     = 8,
  parameter int GEN_LIMIT = 100
) (
  input  logic               clka,
  input  logic               restart_n,
  gol_gen_monitor_if.slave   bus,
  output logic [GEN_W-1:0]   gen_count,
  output logic               dead,
  output logic               still,
  output logic               osc2,
  output logic               halt,
  output logic               overrun,
  output logic               limit_hit
);

`ifdef GOL_MON_GEN_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  mon_state_e       state_q, state_d;
  board_t           cur_q, cur_d, prev_q, prev_d, prev2_q, prev2_d;
  logic             lose_q, lose_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             dead_q, dead_d, still_q, still_d, osc2_q, osc2_d;
  logic             overrun_q, overrun_d, limit_q, limit_d;
  logic             ser_load, ser_done;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    prev_d    = prev_q;
    prev2_d   = prev2_q;
    lose_d    = lose_q;
    gen_d     = gen_q;
    dead_d    = dead_q;
    still_d   = still_q;
    osc2_d    = osc2_q;
    overrun_d = overrun_q;
    limit_d   = limit_q;
    ser_load  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.board_valid) begin
          prev2_d = prev_q;
          prev_d  = cur_q;
          cur_d   = bus.board_in;
          lose_d  = bus.lose_in;
          if (gen_q != '1) gen_d = gen_q + GEN_W'(1);
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (bus.board_valid) overrun_d = 1'b1;
        if (board_is_dead(cur_q, lose_q)) dead_d = 1'b1;
        if (gen_q >= GEN_W'(2) && cur_q == prev_q) still_d = 1'b1;
        if (gen_q >= GEN_W'(3) && cur_q == prev2_q && cur_q != prev_q) osc2_d = 1'b1;
        if (LIMIT_EN && gen_q >= GEN_W'(GEN_LIMIT)) limit_d = 1'b1;
        ser_load = 1'b1;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        if (bus.board_valid) overrun_d = 1'b1;
        if (ser_done) begin
          state_d = (dead_q | still_q | osc2_q | limit_q) ? S_HALT : S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      prev_q    <= '0;
      prev2_q   <= '0;
      lose_q    <= 1'b0;
      gen_q     <= '0;
      dead_q    <= 1'b0;
      still_q   <= 1'b0;
      osc2_q    <= 1'b0;
      overrun_q <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      prev_q    <= prev_d;
      prev2_q   <= prev2_d;
      lose_q    <= lose_d;
      gen_q     <= gen_d;
      dead_q    <= dead_d;
      still_q   <= still_d;
      osc2_q    <= osc2_d;
      overrun_q <= overrun_d;
      limit_q   <= limit_d;
    end
  end

  gol_board_serializer u_ser (
    .clka      (clka),
    .restart_n (restart_n),
    .load_i    (ser_load),
    .data_i    (cur_q),
    .ready_i   (bus.ser_ready),
    .valid_o   (bus.ser_valid),
    .data_o    (bus.ser_data),
    .last_o    (bus.ser_last),
    .done_o    (ser_done)
  );

  assign gen_count = gen_q;
  assign dead      = dead_q;
  assign still     = still_q;
  assign osc2      = osc2_q;
  assign halt      = (state_q == S_HALT);
  assign overrun   = overrun_q;
  assign limit_hit = limit_q;

endmodule

// File: tb/tb_gol_gen_monitor.sv
// Directed bench for gol_gen_monitor: board table plus stall, overrun, reset and saturation sequences.
module tb_gol_gen_monitor;
  import gol_pkg::*;

`ifdef GOL_MON_GEN_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic       clka = 1'b0;
  logic       restart_n = 1'b0;
  logic [7:0] gen_count;
  logic       dead, still, osc2, halt, overrun, limit_hit;

  gol_gen_monitor_if bus ();

  gol_gen_monitor #(.GEN_W(8), .GEN_LIMIT(3)) dut (
    .clka      (clka),
    .restart_n (restart_n),
    .bus       (bus),
    .gen_count (gen_count),
    .dead      (dead),
    .still     (still),
    .osc2      (osc2),
    .halt      (halt),
    .overrun   (overrun),
    .limit_hit (limit_hit)
  );

  always #5 clka = ~clka;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    restart_n = 1'b0;
    bus.board_valid = 1'b0;
    @(negedge clka);
    @(negedge clka);
    restart_n = 1'b1;
  endtask

  // Pulses board_valid for one cycle; returns at the negedge while in COMPARE.
  task automatic pulse_board(input board_t b, input logic lose);
    bus.board_valid = 1'b1;
    bus.board_in    = b;
    bus.lose_in     = lose;
    @(negedge clka);
    bus.board_valid = 1'b0;
    bus.lose_in     = 1'b0;
  endtask

  // Drains one frame with ready held high; returns after the last handshake edge.
  task automatic drain_frame(output board_t got, output logic last_ok, output logic to);
    int t;
    got = '0; last_ok = 1'b1; to = 1'b0;
    bus.ser_ready = 1'b1;
    for (int k = 0; k < BOARD_W; k++) begin
      t = 0;
      while (!bus.ser_valid && t < 50) begin
        @(negedge clka);
        t++;
      end
      if (!bus.ser_valid) begin
        to = 1'b1;
        break;
      end
      got[k] = bus.ser_data;
      if (bus.ser_last !== (k == BOARD_W - 1)) last_ok = 1'b0;
      @(negedge clka);
    end
  endtask

  typedef struct {
    logic       rst;
    board_t     board;
    logic       lose;
    logic [7:0] gen;
    logic       dead;
    logic       still;
    logic       osc2;
    logic       lim;
    logic       halt;
  } vec_t;

  vec_t   vecs[12];
  int     n_vec;
  board_t got, prev_data;
  logic   last_ok, to, prev_stall, prev_last;
  int     k, cyc, last_cnt;

  initial begin
    bus.board_valid = 1'b0;
    bus.board_in    = '0;
    bus.lose_in     = 1'b0;
    bus.ser_ready   = 1'b1;

    vecs[0] = '{1'b1, 16'h0000, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 16'h0033, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h0033, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0070, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 16'h0222, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h0070, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, LIM,  1'b1};
    vecs[6] = '{1'b1, 16'h0001, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'h0002, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'h0004, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, LIM,  LIM};
    vecs[9] = '{1'b1, 16'h0F0F, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    n_vec = 10;
`ifndef GOL_MON_GEN_LIMIT_EN
    vecs[10] = '{1'b0, 16'h0008, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Reorder so the fourth board follows the 1,2,4 sequence.
    vecs[11] = vecs[9];
    vecs[9]  = vecs[10];
    vecs[10] = vecs[11];
    n_vec = 11;
`endif

    // Outputs while reset is asserted.
    @(negedge clka);
    @(negedge clka);
    chk("rst_gen", 32'(gen_count), 32'd0);
    chk("rst_flags", {dead, still, osc2, halt, overrun, limit_hit}, 32'd0);
    chk("rst_ser", {bus.ser_valid, bus.ser_data, bus.ser_last}, 32'd0);
    restart_n = 1'b1;
    @(negedge clka);

    for (int i = 0; i < n_vec; i++) begin
      if (vecs[i].rst) do_reset();
      pulse_board(vecs[i].board, vecs[i].lose);
      chk($sformatf("v%0d_gen", i), 32'(gen_count), 32'(vecs[i].gen));
      @(negedge clka);
      chk($sformatf("v%0d_valid", i), 32'(bus.ser_valid), 32'd1);
      chk($sformatf("v%0d_flags", i), {dead, still, osc2, limit_hit},
          {vecs[i].dead, vecs[i].still, vecs[i].osc2, vecs[i].lim});
      drain_frame(got, last_ok, to);
      chk($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
      chk($sformatf("v%0d_bits", i), 32'(got), 32'(vecs[i].board));
      chk($sformatf("v%0d_last", i), 32'(last_ok), 32'd1);
      chk($sformatf("v%0d_halt", i), {halt, bus.ser_valid}, {vecs[i].halt, 1'b0});
    end

    // HALT ignores board_valid: no overrun, no capture.
    do_reset();
    pulse_board(16'h0000, 1'b0);
    @(negedge clka);
    drain_frame(got, last_ok, to);
    pulse_board(16'h1234, 1'b0);
    @(negedge clka);
    chk("halt_ignore", {halt, overrun, 8'(gen_count), bus.ser_valid}, {1'b1, 1'b0, 8'd1, 1'b0});

    // Stalled stream of 0x8001 with ready pattern 1,0,0,1.
    do_reset();
    pulse_board(16'h8001, 1'b0);
    @(negedge clka);
    k = 0; cyc = 0; last_cnt = 0; got = '0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (k < BOARD_W && cyc < 200) begin
      bus.ser_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (prev_stall) begin
        chk("stall_data", 32'(bus.ser_data), 32'(prev_data[0]));
        chk("stall_last", 32'(bus.ser_last), 32'(prev_last));
      end
      if (bus.ser_last) last_cnt++;
      if (bus.ser_valid && bus.ser_ready) begin
        got[k] = bus.ser_data;
        chk($sformatf("stall_last_b%0d", k), 32'(bus.ser_last), 32'(k == BOARD_W - 1));
        k++;
      end
      prev_stall   = bus.ser_valid && !bus.ser_ready;
      prev_data[0] = bus.ser_data;
      prev_last    = bus.ser_last;
      @(negedge clka);
      cyc++;
    end
    bus.ser_ready = 1'b1;
    chk("stall_done", 32'(k), 32'(BOARD_W));
    chk("stall_bits", 32'(got), 32'h8001);
    chk("stall_end", {halt, bus.ser_valid}, 32'd0);

    // board_valid mid-SHIFT: overrun set, frame intact, count unchanged.
    do_reset();
    pulse_board(16'h00F0, 1'b0);
    @(negedge clka);
    got = '0;
    for (int b = 0; b < BOARD_W; b++) begin
      if (b == 5) begin
        bus.board_valid = 1'b1;
        bus.board_in    = 16'hFFFF;
      end else begin
        bus.board_valid = 1'b0;
      end
      got[b] = bus.ser_data;
      @(negedge clka);
    end
    bus.board_valid = 1'b0;
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_gen", 32'(gen_count), 32'd1);
    chk("ovr_bits", 32'(got), 32'h00F0);

    // Reset in the middle of the next frame.
    pulse_board(16'h0011, 1'b0);
    @(negedge clka);
    repeat (4) @(negedge clka);
    chk("mid_valid", 32'(bus.ser_valid), 32'd1);
    restart_n = 1'b0;
    @(negedge clka);
    chk("mid_rst_out", {8'(gen_count), dead, still, osc2, halt, overrun, limit_hit,
        bus.ser_valid, bus.ser_data, bus.ser_last}, 32'd0);
    restart_n = 1'b1;
    @(negedge clka);

`ifndef GOL_MON_GEN_LIMIT_EN
    // Saturation: 257 distinct nonzero boards never trigger a flag.
    for (int n = 1; n <= 257; n++) begin
      pulse_board(board_t'(n), 1'b0);
      @(negedge clka);
      drain_frame(got, last_ok, to);
      if (to) break;
    end
    chk("sat_gen", 32'(gen_count), 32'd255);
    chk("sat_flags", {dead, still, osc2, halt}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gol_gen_monitor.md
Name: gol_gen_monitor

Overview:
- Downstream stage of the Game-of-Life datapath. Consumes each completed 16-cell generation (the 4x4 toroidal board) when the datapath commits it.
- Counts generations and detects end-of-game conditions: extinction, still life and period-2 oscillation.
- Streams every generation out bit-serially over a valid/ready handshake to the display/pad interface.

Parameters:
- BOARD_W, 16, cells per board (4x4 torus, bit index = row*4+col).
- GEN_W, 8, generation counter width.
- GEN_LIMIT, 100, generation cap; used only when the optional feature is compiled in.

Ports:
- clka, input, 1, single system clock, rising edge.
- restart_n, input, 1, synchronous active-low reset.
- board_valid, input, 1, one-cycle pulse: new generation available (coincident with datapath writeout).
- board_in, input, BOARD_W, generation just computed by the datapath.
- lose_in, input, 1, datapath lose signal, sampled with board_valid.
- ser_ready, input, 1, sink ready.
- ser_valid, output, 1, serial bit valid.
- ser_data, output, 1, serial cell bit, LSB (cell 0) first.
- ser_last, output, 1, high with cell BOARD_W-1.
- gen_count, output, GEN_W, generations captured since reset; saturating.
- dead, output, 1, sticky: board all zero or lose_in seen.
- still, output, 1, sticky: board identical to previous generation.
- osc2, output, 1, sticky: board equals generation-2 and differs from generation-1.
- halt, output, 1, game over; monitor frozen.
- overrun, output, 1, sticky: board_valid arrived while not IDLE.
- limit_hit, output, 1, generation cap reached (tied 0 when feature absent).

Behaviour:
- Reset (restart_n=0 at a clka edge): all outputs 0. Internal cur/prev/prev2 cleared, history-valid count cleared, state IDLE.
- Reset takes priority over everything, including mid-serialization. ser_valid drops on the next edge; the partial frame is abandoned.
- FSM states: IDLE, COMPARE, SHIFT, HALT.
- IDLE:
  - On board_valid: prev2<=prev, prev<=cur, cur<=board_in, lose latched, gen_count+1 (holds at all-ones), go to COMPARE.
- COMPARE (exactly one cycle):
  - Set dead if cur==0 or latched lose.
  - Set still if gen_count>=2 and cur==prev.
  - Set osc2 if gen_count>=3, cur==prev2 and cur!=prev.
  - Flags are sticky until reset. Go to SHIFT.
- SHIFT:
  - ser_valid=1, ser_data=cur[idx], idx starts at 0.
  - idx advances only on ser_valid&&ser_ready. ser_data is stable while stalled.
  - ser_last=1 when idx==BOARD_W-1.
  - When the last bit is accepted: go to HALT if dead|still|osc2 (or limit reached, see option), else IDLE.
- HALT: halt=1, ser_valid=0; board_valid ignored (no overrun set). Exit only by reset.
- Latency: board_valid sampled at edge N; flags visible after edge N+1; first ser_valid after edge N+1. A frame takes at least 16 cycles.
- board_valid in COMPARE or SHIFT: data dropped, overrun<=1, gen_count unchanged.
- gen_count saturates at 2^GEN_W-1; comparisons continue normally.

Optional Feature:
- Macro GOL_MON_GEN_LIMIT_EN.
- Defined: when gen_count reaches GEN_LIMIT at capture, limit_hit sets in COMPARE and the FSM enters HALT after that frame serializes.
- Undefined: limit_hit tied to 0, no cap, GEN_LIMIT unused.

Decomposition:
- Shared package gol_pkg: BOARD_W, a board typedef (logic [BOARD_W-1:0]), and the monitor state enum. The datapath reuses BOARD_W.
- Sub-module gol_board_serializer: BOARD_W-bit parallel-in/serial-out with valid/ready, a load strobe and a last/done output.
- The monitor keeps the FSM, history registers and comparators.

Test Plan:
- Reset, then board_valid with 0x0000 -> gen_count=1, dead=1; 16 zero bits serialized; halt=1 after the last bit.
- Feed 0x0033, then 0x0033 (ser_ready held 1) -> still=1 after the second COMPARE, gen_count=2, halt after the second frame.
- Feed 0x0070, 0x0222, 0x0070 -> osc2=1 at gen 3, still=0, dead=0, halt.
- Board 0x8001 with ser_ready toggling 1,0,0,1... -> bit order 1,0x14,1, ser_data stable during stalls, ser_last only on bit 15.
- board_valid pulsed mid-SHIFT -> overrun=1, gen_count unchanged, frame completes intact. Then restart_n=0 mid-frame -> all outputs 0 next cycle.
- With GOL_MON_GEN_LIMIT_EN and GEN_LIMIT=3, feed 0x0001, 0x0002, 0x0004 -> limit_hit=1, halt after the third frame. Without the macro -> limit_hit stays 0 and a fourth board is accepted.
